// File: rtl/weight_pad_streamer_pkg.sv
// weight_pad_streamer_pkg: shared widths, FSM encoding and helpers for the kernel pad streamer
package weight_pad_streamer_pkg;
    localparam int W_BITS = 8;
    localparam int WORD_BITS = 32;
    localparam int LANES = 4;
    typedef enum logic [2:0] {IDLE, REQ, CAP, STREAM, DONE} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
    function automatic logic [W_BITS-1:0] lane_sel(input logic [WORD_BITS-1:0] w, input logic [1:0] l);
        return w[l*W_BITS +: W_BITS];
    endfunction
endpackage

// File: rtl/weight_pad_streamer_if.sv
// weight_pad_streamer_if: weight SRAM read port plus padded-sample stream toward the FFT
interface weight_pad_streamer_if #(
    parameter int ADDR_W = 16,
    parameter int RC_W = 3
);
    import weight_pad_streamer_pkg::*;
    logic sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [WORD_BITS-1:0] sram_q;
    logic w_valid;
    logic w_ready;
    logic signed [W_BITS-1:0] w_data;
    logic [RC_W-1:0] w_row;
    logic [RC_W-1:0] w_col;
    logic w_last;
    modport master(
        output sram_wen, sram_addr, w_valid, w_data, w_row, w_col, w_last,
        input sram_q, w_ready
    );
    modport slave(
        input sram_wen, sram_addr, w_valid, w_data, w_row, w_col, w_last,
        output sram_q, w_ready
    );
endinterface

// File: rtl/weight_pad_streamer_pad_scan_counter.sv
// pad_scan_counter: row-major walk of the padded grid with kernel-membership lookahead
module pad_scan_counter
    import weight_pad_streamer_pkg::*;
#(
    parameter int KERNEL_H = 3,
    parameter int KERNEL_W = 3,
    parameter int FFT_N = 8,
    parameter int RC_W = clog2(FFT_N),
    parameter int K_W = 2 * RC_W + 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic [RC_W-1:0] row,
    output logic [RC_W-1:0] col,
    output logic last,
    output logic in_kernel,
    output logic [1:0] lane,
    output logic nxt_in_kernel,
    output logic [K_W-1:0] nxt_k
);
    logic [RC_W-1:0] nxt_row, nxt_col;
    // FFT_N is a power of two, so plain increments wrap the grid for free
    assign nxt_col = col + 1'b1;
    assign nxt_row = (&col) ? row + 1'b1 : row;
    assign last = &{row, col};
    assign in_kernel = int'(row) < KERNEL_H && int'(col) < KERNEL_W;
    assign lane = 2'(int'(row) * KERNEL_W + int'(col));
    assign nxt_in_kernel = int'(nxt_row) < KERNEL_H && int'(nxt_col) < KERNEL_W;
    assign nxt_k = K_W'(int'(nxt_row) * KERNEL_W + int'(nxt_col));
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            row <= nxt_row;
            col <= nxt_col;
        end
    end
endmodule

// File: rtl/weight_pad_streamer.sv
// weight_pad_streamer: fetches an int8 kernel from weight SRAM and streams it zero-padded to FFT_N x FFT_N
module weight_pad_streamer
    import weight_pad_streamer_pkg::*;
#(
    parameter int KERNEL_H = 3,
    parameter int KERNEL_W = 3,
    parameter int FFT_N = 8,
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    weight_pad_streamer_if.master bus
);
    localparam int RC_W = clog2(FFT_N);
    localparam int K_W = 2 * RC_W + 2;
    if (KERNEL_H < 1 || KERNEL_W < 1 || KERNEL_H > FFT_N || KERNEL_W > FFT_N ||
        FFT_N < 2 || (FFT_N & (FFT_N - 1)) != 0) begin : g_bad_cfg
        $error("weight_pad_streamer: kernel must fit a power-of-two FFT_N >= 2");
    end
    state_t state;
    logic [WORD_BITS-1:0] wbuf;
    logic [K_W-3:0] buf_word;
    logic [ADDR_W-1:0] addr;
    logic valid, hs, fetch, last, in_kernel, nxt_in_kernel;
    logic signed [W_BITS-1:0] data;
    logic [1:0] lane;
    logic [K_W-1:0] nxt_k;
    pad_scan_counter #(
        .KERNEL_H(KERNEL_H), .KERNEL_W(KERNEL_W), .FFT_N(FFT_N), .RC_W(RC_W), .K_W(K_W)
    ) u_scan (
        .clk(clk), .rst(rst), .en(hs), .row(bus.w_row), .col(bus.w_col), .last(last),
        .in_kernel(in_kernel), .lane(lane), .nxt_in_kernel(nxt_in_kernel), .nxt_k(nxt_k)
    );
    assign hs = valid & bus.w_ready;
    // only a kernel element outside the buffered word costs a read; padding never does
    assign fetch = nxt_in_kernel && nxt_k[K_W-1:2] != buf_word;
    assign bus.sram_wen = 1'b0;
    assign bus.sram_addr = addr;
    assign bus.w_valid = valid;
    assign bus.w_data = data;
    assign bus.w_last = last;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            valid <= 1'b0;
            data <= '0;
            addr <= '0;
            wbuf <= '0;
            buf_word <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= REQ;
                    busy <= 1'b1;
                    addr <= BASE_ADDR;
                    buf_word <= '0;
                end
                REQ: state <= CAP;
                CAP: begin
                    state <= STREAM;
                    valid <= 1'b1;
                    wbuf <= bus.sram_q;
                    data <= in_kernel ? lane_sel(bus.sram_q, lane) : '0;
                end
                STREAM: if (hs) begin
                    state <= last ? DONE : fetch ? REQ : STREAM;
                    valid <= !(last || fetch);
                    done <= last;
                    data <= nxt_in_kernel ? lane_sel(wbuf, nxt_k[1:0]) : '0;
                    if (fetch && !last) begin
                        addr <= BASE_ADDR + ADDR_W'({nxt_k[K_W-1:2], 2'b00});
                        buf_word <= nxt_k[K_W-1:2];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
